// File: rtl/ps2_scan_decoder_if.sv
// Keyboard-side pins and decoded key stream of the PS/2 scan-code front end.
// slave: the decoder. master: whatever drives the PS/2 lines and consumes keys.
interface ps2_scan_decoder_if;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic [7:0] o_key_code;
  logic       o_key_valid;
  logic       o_is_upper;
  logic       o_shift_on;
  logic       o_frame_err;

  modport slave (
    input  i_ps2_clk, i_ps2_data,
    output o_key_code, o_key_valid, o_is_upper, o_shift_on, o_frame_err
  );

  modport master (
    output i_ps2_clk, i_ps2_data,
    input  o_key_code, o_key_valid, o_is_upper, o_shift_on, o_frame_err
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: filters ps2_clk, deframes 11-bit frames, strips E0/F0, tracks Shift/Caps.
// Key strobe 2 cycles after the stop-bit edge; no backpressure. Optional PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_scan_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ps2_scan_decoder_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} fstate_t;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_s, din;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fe_q, fe_d;

  fstate_t       fstate_q, fstate_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          err_q, err_d;
  logic          par_ok;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          sl_q, sl_d, sr_q, sr_d;
  logic          caps_q, caps_d, held_q, held_d;
  logic [7:0]    key_q, key_d;
  logic          kvld_q, kvld_d;
  logic          upper_q, upper_d, shon_q, shon_d;

  assign clk_s = clk_sync_q[1];
  assign din   = data_sync_q[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      fe_q        <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.i_ps2_clk};
      data_sync_q <= {data_sync_q[0], bus.i_ps2_data};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fe_q        <= fe_d;
    end
  end

  // Any sample equal to the current filtered level restarts the run count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fe_d   = 1'b0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
        fe_d   = !clk_s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) par_q <= 1'b0;
    else          par_q <= par_d;
  end

  always_comb begin
    par_d = par_q;
    if (fstate_q == F_PARITY && fe_q) par_d = din;
  end

  assign par_ok = ^{shreg_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fstate_q   <= F_IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      tmo_q      <= '0;
      byte_rdy_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fstate_q   <= fstate_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
      byte_rdy_q <= byte_rdy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    fstate_d   = fstate_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    byte_rdy_d = 1'b0;
    err_d      = 1'b0;
    tmo_d      = (fstate_q == F_IDLE || fe_q) ? '0 : tmo_q + 1'b1;
    case (fstate_q)
      F_IDLE: begin
        if (fe_q) begin
          if (!din) begin
            fstate_d = F_DATA;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      F_DATA: begin
        if (fe_q) begin
          shreg_d  = {din, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) fstate_d = F_PARITY;
        end
      end
      F_PARITY: begin
        if (fe_q) fstate_d = F_STOP;
      end
      F_STOP: begin
        if (fe_q) begin
          if (din && par_ok) byte_rdy_d = 1'b1;
          else               err_d      = 1'b1;
          fstate_d = F_IDLE;
        end
      end
      default: fstate_d = F_IDLE;
    endcase
    // A stalled keyboard must not leave a half-received frame waiting forever.
    if (fstate_q != F_IDLE && !fe_q && tmo_d == TW'(TIMEOUT_CYC)) begin
      fstate_d = F_IDLE;
      bitcnt_d = '0;
      shreg_d  = '0;
      tmo_d    = '0;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      caps_q  <= 1'b0;
      held_q  <= 1'b0;
      key_q   <= '0;
      kvld_q  <= 1'b0;
      upper_q <= 1'b0;
      shon_q  <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      caps_q  <= caps_d;
      held_q  <= held_d;
      key_q   <= key_d;
      kvld_q  <= kvld_d;
      upper_q <= upper_d;
      shon_q  <= shon_d;
    end
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    sl_d   = sl_q;
    sr_d   = sr_q;
    caps_d = caps_q;
    held_d = held_q;
    key_d  = key_q;
    kvld_d = 1'b0;
    if (byte_rdy_q) begin
      if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Extended keys are dropped entirely, prefixes included.
        if (!ext_q) begin
          case (shreg_q)
            8'h12: sl_d = !brk_q;
            8'h59: sr_d = !brk_q;
            8'h58: begin
              if (brk_q) begin
                held_d = 1'b0;
              end else if (!held_q) begin
                caps_d = !caps_q;
                held_d = 1'b1;
              end
            end
            8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: begin
            end
            default: begin
              if (!brk_q) begin
                key_d  = shreg_q;
                kvld_d = 1'b1;
              end
            end
          endcase
        end
      end
    end
    shon_d  = sl_d | sr_d;
    upper_d = caps_d ^ shon_d;
  end

  assign bus.o_key_code  = key_q;
  assign bus.o_key_valid = kvld_q;
  assign bus.o_is_upper  = upper_q;
  assign bus.o_shift_on  = shon_q;
  assign bus.o_frame_err = err_q;

endmodule
